// File: rtl/imem_load_ctrl.sv
// Instruction memory shared between a sequential program loader and the CPU fetch port.
// The sequencer stalls the CPU until an image is loaded, then serves registered fetches.
module imem_load_ctrl #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [7:0]    ld_count,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic [DW-1:0] if_instr,
    output logic          if_valid,
    output logic          cpu_stall,
    output logic          running,
    output logic          addr_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW-1:0] ptr;
    logic [DW-1:0] mem [DEPTH];

    logic          accept;
    logic          fetch;
    logic          in_range;
    logic          ptr_end;
    logic [AW-1:0] idx;

    assign ld_ready  = (state == LOAD);
    assign running   = (state == RUN);
    assign cpu_stall = (state != RUN);

    // ld_start wins over any same-cycle loader word or fetch
    assign accept   = ld_ready & ld_valid & ~ld_start;
    assign fetch    = running & if_req & ~ld_start;
    assign idx      = if_addr[AW+1:2];
    assign in_range = (if_addr[31:AW+2] == '0) && (if_addr[1:0] == 2'b00);
    assign ptr_end  = (ptr == AW'(DEPTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = IDLE;
            LOAD: begin
                if (accept && (ld_last || ptr_end)) begin
                    state_nxt = RUN;
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        if (ld_start) begin
            state_nxt = LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            ld_count <= '0;
        end else if (ld_start) begin
            ptr      <= '0;
            ld_count <= '0;
        end else if (accept) begin
            if (!ptr_end) begin
                ptr <= ptr + 1'b1;
            end
            if (ld_count != 8'(DEPTH)) begin
                ld_count <= ld_count + 8'd1;
            end
        end
    end

    // Storage has no reset so an abandoned image keeps its written words
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_instr <= '0;
            if_valid <= 1'b0;
        end else begin
            if_valid <= fetch;
            if (fetch) begin
                if_instr <= in_range ? mem[idx] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (ld_start) begin
            addr_err <= 1'b0;
        end else if (fetch && !in_range) begin
            addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: directed scenarios plus random traffic,
// fetch results checked through a scoreboard queue.
module tb_imem_load_ctrl;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic [7:0]  ld_count;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        cpu_stall;
    logic        running;
    logic        addr_err;

    imem_load_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_count(ld_count),
        .if_req(if_req), .if_addr(if_addr),
        .if_instr(if_instr), .if_valid(if_valid),
        .cpu_stall(cpu_stall), .running(running),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [31:0] d;
        bit          known;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   edge_n = 0;

    // reference model: image contents and loader/run status
    logic [31:0] mmem [DEPTH];
    bit          mwr [DEPTH];
    bit          m_load, m_run, m_err;
    int          m_ptr, m_cnt;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endfunction

    function automatic void model_reset();
        m_load = 0; m_run = 0; m_err = 0; m_ptr = 0; m_cnt = 0;
    endfunction

    task automatic check_status();
        chk("cpu_stall", 32'(cpu_stall), 32'(!m_run));
        chk("running", 32'(running), 32'(m_run));
        chk("ld_ready", 32'(ld_ready), 32'(m_load));
        chk("ld_count", 32'(ld_count), 32'(m_cnt));
        chk("addr_err", 32'(addr_err), 32'(m_err));
    endtask

    task automatic step(bit st, bit v, logic [31:0] d, bit l,
                        bit rq, logic [31:0] ad);
        bit   ok;
        exp_t x;
        @(negedge clk);
        check_status();
        ld_start = st; ld_valid = v; ld_data = d; ld_last = l;
        if_req = rq; if_addr = ad;
        if (rq && m_run && !st) begin
            ok = (ad[31:9] == 0) && (ad[1:0] == 0);
            x.e = edge_n + 1;
            x.d = ok ? mmem[ad[8:2]] : 32'h0;
            x.known = ok ? mwr[ad[8:2]] : 1'b1;
            q.push_back(x);
            if (!ok) m_err = 1;
        end
        if (st) begin
            m_load = 1; m_run = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
        end else if (m_load && v) begin
            mmem[m_ptr] = d;
            mwr[m_ptr] = 1;
            m_ptr++;
            m_cnt++;
            if (l || m_ptr == DEPTH) begin
                m_load = 0;
                m_run = 1;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic fetch(logic [31:0] ad);
        step(0, 0, 32'h0, 0, 1, ad);
    endtask

    task automatic check_reset_outputs();
        chk("rst if_instr", if_instr, 32'h0);
        chk("rst if_valid", 32'(if_valid), 32'h0);
        chk("rst cpu_stall", 32'(cpu_stall), 32'h1);
        chk("rst ld_ready", 32'(ld_ready), 32'h0);
        chk("rst running", 32'(running), 32'h0);
        chk("rst addr_err", 32'(addr_err), 32'h0);
        chk("rst ld_count", 32'(ld_count), 32'h0);
    endtask

    // monitor: every edge, if_valid must match exactly the queued fetches
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (if_valid) begin
                if (q.size() == 0 || q[0].e != edge_n) begin
                    checks++; fails++;
                    $display("FAIL if_valid: got 1 expected 0 at edge %0d", edge_n);
                end else begin
                    x = q.pop_front();
                    if (x.known) chk("if_instr", if_instr, x.d);
                    else checks++;
                end
            end else if (q.size() > 0 && q[0].e == edge_n) begin
                checks++; fails++;
                $display("FAIL if_valid: got 0 expected 1 at edge %0d", edge_n);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mwr[i] = 0;
        model_reset();
        #2;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // small image, single and back-to-back fetches
        step(1, 0, 32'h0, 0, 0, 32'h0);
        step(0, 1, 32'h2008_0020, 0, 0, 32'h0);
        step(0, 1, 32'h2009_0037, 0, 0, 32'h0);
        step(0, 1, 32'h0109_8024, 1, 0, 32'h0);
        fetch(32'h0); idle();
        fetch(32'h4); idle();
        fetch(32'h8); idle();
        fetch(32'h8); fetch(32'h0); fetch(32'h4);
        idle();

        // full image without ld_last, then extra word ignored
        step(1, 0, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, $urandom, 0, 0, 32'h0);
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        fetch(32'h1FC); idle();

        // bad addresses set sticky addr_err, good fetch still works
        fetch(32'h202); fetch(32'h200); idle();
        fetch(32'h4); idle();

        // reload with same-cycle fetch dropped, then 2-word image
        step(1, 0, 32'h0, 0, 1, 32'h0);
        step(0, 1, 32'hAAAA_0001, 0, 0, 32'h0);
        step(0, 1, 32'hBBBB_0002, 1, 0, 32'h0);
        fetch(32'h0); fetch(32'h4); idle();

        // async reset in the middle of a load
        step(1, 0, 32'h0, 0, 0, 32'h0);
        step(0, 1, 32'h1111_1111, 0, 0, 32'h0);
        step(0, 1, 32'h2222_2222, 0, 0, 32'h0);
        @(negedge clk);
        ld_valid = 0; if_req = 0; ld_start = 0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 32'h3333_3333, 0, 0, 32'h0);
        step(0, 1, 32'h4444_4444, 1, 0, 32'h0);
        idle();

        // random traffic
        n = 0;
        while (n < 1500) begin
            bit          st, v, l, rq;
            logic [31:0] ad;
            st = ($urandom_range(0, 39) == 0) || (!m_load && !m_run);
            v  = $urandom_range(0, 3) != 0;
            l  = $urandom_range(0, 9) == 0;
            rq = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 9) < 8) ad = {23'h0, 7'($urandom), 2'b00};
            else ad = $urandom;
            step(st, v, $urandom, l, rq, ad);
            n++;
        end
        idle();
        idle();
        chk("scoreboard empty", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
